// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: write ports, late-write port, reservation port and read ports.
interface regfile_sb_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
);
    logic             WE3;
    logic [AW-1:0]    A3;
    logic [WIDTH-1:0] WD3;
    logic             WE4;
    logic [AW-1:0]    A4;
    logic [WIDTH-1:0] WD4;
    logic             RSV;
    logic [AW-1:0]    RA;
    logic             RSV_OK;
    logic [AW-1:0]    A1;
    logic [AW-1:0]    A2;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic             BUSY1;
    logic             BUSY2;

    modport master (
        output WE3, A3, WD3, WE4, A4, WD4, RSV, RA, A1, A2,
        input  RSV_OK, RD1, RD2, BUSY1, BUSY2
    );

    modport slave (
        input  WE3, A3, WD3, WE4, A4, WD4, RSV, RA, A1, A2,
        output RSV_OK, RD1, RD2, BUSY1, BUSY2
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with write-back scoreboard: two read ports, in-order and late write ports,
// and a reservation port that marks a destination busy until its late result returns.
module regfile_sb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input logic         CLK,
    input logic         RST,
    regfile_sb_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam bit          ZR    = (ZERO_REG != 0);
    localparam bit          BP    = (BYPASS != 0);

    logic [WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             we3_ok;
    logic             we4_ok;
    logic             rsv_busy;
    logic             rsv_ok;
    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];
    logic             rbusy [2];

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    // Qualified writes and reservation acceptance
    always_comb begin
        we3_ok   = bus.WE3 && !is_zero(bus.A3);
        we4_ok   = bus.WE4 && !is_zero(bus.A4);
        rsv_busy = busy[bus.RA];
        if (BP && we4_ok && (bus.A4 == bus.RA)) begin
            rsv_busy = 1'b0;
        end
        rsv_ok = bus.RSV && !rsv_busy && !is_zero(bus.RA);
    end

    // Late-write clear is applied before the reservation set
    always_comb begin
        busy_nxt = busy;
        if (we4_ok) begin
            busy_nxt[bus.A4] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[bus.RA] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            busy <= busy_nxt;
            if (we4_ok) begin
                rf[bus.A4] <= bus.WD4;
            end
            // Primary write is younger, so it wins an address collision
            if (we3_ok) begin
                rf[bus.A3] <= bus.WD3;
            end
        end
    end

    assign raddr[0] = bus.A1;
    assign raddr[1] = bus.A2;

    // Read ports: optional same-cycle forwarding, zero-register masking last
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = rf[raddr[p]];
            rbusy[p] = busy[raddr[p]];
            if (BP) begin
                if (we3_ok && (bus.A3 == raddr[p])) begin
                    rdata[p] = bus.WD3;
                end else if (we4_ok && (bus.A4 == raddr[p])) begin
                    rdata[p] = bus.WD4;
                end
                if (we4_ok && (bus.A4 == raddr[p])) begin
                    rbusy[p] = 1'b0;
                end
            end
            if (is_zero(raddr[p])) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign bus.RSV_OK = rsv_ok;
    assign bus.RD1    = rdata[0];
    assign bus.RD2    = rdata[1];
    assign bus.BUSY1  = rbusy[0];
    assign bus.BUSY2  = rbusy[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two configurations (zero-reg+bypass, plain) driven in lockstep
// against an array model, plus hand-computed directed expectations.
module tb_regfile_sb;
    logic        clk;
    logic        rst;
    logic        we3, we4, rsv;
    logic [4:0]  a3, a4, ra, a1, a2;
    logic [31:0] wd3, wd4;
    logic        chk_en;
    int          n_cmp;
    int          n_bad;

    // Model state: index 0 = ZERO_REG=1/BYPASS=1, index 1 = ZERO_REG=0/BYPASS=0
    logic [31:0] m_rf   [2][32];
    logic        m_busy [2][32];

    regfile_sb_if #(.WIDTH(32), .AW(5)) bus0 ();
    regfile_sb_if #(.WIDTH(32), .AW(5)) bus1 ();

    assign bus0.WE3 = we3;  assign bus1.WE3 = we3;
    assign bus0.A3  = a3;   assign bus1.A3  = a3;
    assign bus0.WD3 = wd3;  assign bus1.WD3 = wd3;
    assign bus0.WE4 = we4;  assign bus1.WE4 = we4;
    assign bus0.A4  = a4;   assign bus1.A4  = a4;
    assign bus0.WD4 = wd4;  assign bus1.WD4 = wd4;
    assign bus0.RSV = rsv;  assign bus1.RSV = rsv;
    assign bus0.RA  = ra;   assign bus1.RA  = ra;
    assign bus0.A1  = a1;   assign bus1.A1  = a1;
    assign bus0.A2  = a2;   assign bus1.A2  = a2;

    regfile_sb #(.WIDTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .CLK (clk),
        .RST (rst),
        .bus (bus0.slave)
    );

    regfile_sb #(.WIDTH(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
        bit zr;
        bit bp;
        zr = (c == 0);
        bp = (c == 0);
        if (zr && a == 5'd0) return 32'd0;
        if (bp && we3 && a3 == a) return wd3;
        if (bp && we4 && a4 == a) return wd4;
        return m_rf[c][a];
    endfunction

    function automatic logic exp_busy(input int c, input logic [4:0] a);
        bit zr;
        bit bp;
        zr = (c == 0);
        bp = (c == 0);
        if (zr && a == 5'd0) return 1'b0;
        if (bp && we4 && a4 == a) return 1'b0;
        return m_busy[c][a];
    endfunction

    function automatic logic exp_ok(input int c);
        bit zr;
        bit bp;
        logic b;
        zr = (c == 0);
        bp = (c == 0);
        if (!rsv) return 1'b0;
        if (zr && ra == 5'd0) return 1'b0;
        b = m_busy[c][ra];
        if (bp && we4 && a4 == ra) b = 1'b0;
        return !b;
    endfunction

    initial begin
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[c][i]   = 32'd0;
                m_busy[c][i] = 1'b0;
            end
        end
    end

    // Model state update at each rising edge
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            logic ok;
            bit   zr;
            zr = (c == 0);
            ok = exp_ok(c);
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_rf[c][i]   = 32'd0;
                    m_busy[c][i] = 1'b0;
                end
            end else begin
                if (we4 && !(zr && a4 == 5'd0)) begin
                    m_rf[c][a4]   = wd4;
                    m_busy[c][a4] = 1'b0;
                end
                if (we3 && !(zr && a3 == 5'd0)) m_rf[c][a3] = wd3;
                if (ok) m_busy[c][ra] = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every combinational output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rd1_c0",  bus0.RD1,   exp_rd(0, a1));
            chk("m_rd2_c0",  bus0.RD2,   exp_rd(0, a2));
            chk("m_bsy1_c0", 32'(bus0.BUSY1),  32'(exp_busy(0, a1)));
            chk("m_bsy2_c0", 32'(bus0.BUSY2),  32'(exp_busy(0, a2)));
            chk("m_ok_c0",   32'(bus0.RSV_OK), 32'(exp_ok(0)));
            chk("m_rd1_c1",  bus1.RD1,   exp_rd(1, a1));
            chk("m_rd2_c1",  bus1.RD2,   exp_rd(1, a2));
            chk("m_bsy1_c1", 32'(bus1.BUSY1),  32'(exp_busy(1, a1)));
            chk("m_bsy2_c1", 32'(bus1.BUSY2),  32'(exp_busy(1, a2)));
            chk("m_ok_c1",   32'(bus1.RSV_OK), 32'(exp_ok(1)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we3 = 1'b0; we4 = 1'b0; rsv = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; chk_en = 1'b0;
        rst = 1'b1; we3 = 1'b0; we4 = 1'b0; rsv = 1'b0;
        a3 = '0; a4 = '0; ra = '0; a1 = '0; a2 = '0; wd3 = '0; wd4 = '0;

        // Reset wins over a same-cycle write
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'hFFFF_FFFF; a1 = 5'd5;
        tick();
        chk_en = 1'b1;
        idle(); a1 = 5'd5;
        @(negedge clk);
        chk("rst_rd1_c0", bus0.RD1, 32'd0);
        chk("rst_bsy1_c0", 32'(bus0.BUSY1), 32'd0);
        chk("rst_rd1_c1", bus1.RD1, 32'd0);
        chk("rst_model", m_rf[0][5], 32'd0);
        tick();

        // Write with and without bypass
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h1234_5678; a1 = 5'd7;
        @(negedge clk);
        chk("byp_rd1_c0", bus0.RD1, 32'h1234_5678);
        chk("nobyp_old_c1", bus1.RD1, 32'd0);
        tick();
        idle(); a1 = 5'd7;
        @(negedge clk);
        chk("wr_rd1_c1", bus1.RD1, 32'h1234_5678);
        chk("wr_model_c1", m_rf[1][7], 32'h1234_5678);
        tick();

        // Scoreboard round trip on r9
        rsv = 1'b1; ra = 5'd9; a2 = 5'd9;
        @(negedge clk);
        chk("rsv_ok_c0", 32'(bus0.RSV_OK), 32'd1);
        chk("rsv_ok_c1", 32'(bus1.RSV_OK), 32'd1);
        chk("rsv_bsy_pre", 32'(bus0.BUSY2), 32'd0);
        tick();
        @(negedge clk);
        chk("rsv_again_c0", 32'(bus0.RSV_OK), 32'd0);
        chk("rsv_bsy2_c0", 32'(bus0.BUSY2), 32'd1);
        chk("rsv_bsy2_c1", 32'(bus1.BUSY2), 32'd1);
        tick();
        idle(); we4 = 1'b1; a4 = 5'd9; wd4 = 32'h0000_CAFE;
        @(negedge clk);
        chk("late_bsy2_c0", 32'(bus0.BUSY2), 32'd0);
        chk("late_rd2_c0", bus0.RD2, 32'h0000_CAFE);
        chk("late_bsy2_c1", 32'(bus1.BUSY2), 32'd1);
        chk("late_rd2_c1", bus1.RD2, 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("late_after_c1", bus1.RD2, 32'h0000_CAFE);
        chk("late_after_b_c1", 32'(bus1.BUSY2), 32'd0);
        tick();

        // Dual-write conflict on busy r3
        rsv = 1'b1; ra = 5'd3;
        tick();
        idle(); we3 = 1'b1; a3 = 5'd3; wd3 = 32'h0000_AAAA;
        we4 = 1'b1; a4 = 5'd3; wd4 = 32'h0000_BBBB; a1 = 5'd3;
        @(negedge clk);
        chk("dual_byp_c0", bus0.RD1, 32'h0000_AAAA);
        chk("dual_bsy_c0", 32'(bus0.BUSY1), 32'd0);
        chk("dual_bsy_c1", 32'(bus1.BUSY1), 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("dual_rd1_c0", bus0.RD1, 32'h0000_AAAA);
        chk("dual_rd1_c1", bus1.RD1, 32'h0000_AAAA);
        chk("dual_bsy_after", 32'(bus1.BUSY1), 32'd0);
        chk("dual_model", m_rf[0][3], 32'h0000_AAAA);
        tick();

        // Zero register
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'h0000_1111;
        we4 = 1'b1; a4 = 5'd0; wd4 = 32'h0000_2222;
        rsv = 1'b1; ra = 5'd0; a1 = 5'd0;
        @(negedge clk);
        chk("zero_rd1_c0", bus0.RD1, 32'd0);
        chk("zero_bsy_c0", 32'(bus0.BUSY1), 32'd0);
        chk("zero_ok_c0", 32'(bus0.RSV_OK), 32'd0);
        chk("zero_ok_c1", 32'(bus1.RSV_OK), 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("zero_after_c0", bus0.RD1, 32'd0);
        chk("zero_rd1_c1", bus1.RD1, 32'h0000_1111);
        chk("zero_bsy_c1", 32'(bus1.BUSY1), 32'd1);
        tick();

        // Reserve/clear collision
        rsv = 1'b1; ra = 5'd4; we4 = 1'b1; a4 = 5'd4; wd4 = 32'h44; a1 = 5'd4;
        @(negedge clk);
        chk("coll_ok_c0", 32'(bus0.RSV_OK), 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("coll_bsy_c0", 32'(bus0.BUSY1), 32'd1);
        chk("coll_bsy_c1", 32'(bus1.BUSY1), 32'd1);
        chk("coll_rd1_c1", bus1.RD1, 32'h44);
        tick();
        rsv = 1'b1; ra = 5'd4; we4 = 1'b1; a4 = 5'd4; wd4 = 32'h55;
        @(negedge clk);
        chk("coll2_ok_c0", 32'(bus0.RSV_OK), 32'd1);
        chk("coll2_ok_c1", 32'(bus1.RSV_OK), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("coll2_bsy_c0", 32'(bus0.BUSY1), 32'd1);
        chk("coll2_bsy_c1", 32'(bus1.BUSY1), 32'd0);
        chk("coll2_rd1_c0", bus0.RD1, 32'h55);
        tick();

        // Mid-operation reset, then a late write lands normally
        rst = 1'b1; rsv = 1'b1; ra = 5'd6;
        tick();
        idle(); a1 = 5'd4;
        @(negedge clk);
        chk("mrst_bsy_c0", 32'(bus0.BUSY1), 32'd0);
        chk("mrst_rd1_c0", bus0.RD1, 32'd0);
        chk("mrst_rd1_c1", bus1.RD1, 32'd0);
        tick();
        we4 = 1'b1; a4 = 5'd4; wd4 = 32'h77;
        tick();
        idle();
        @(negedge clk);
        chk("post_rst_rd1", bus1.RD1, 32'h77);
        tick();

        // Patterned burst on a small address window to stress collisions
        for (int i = 0; i < 48; i++) begin
            rst = (i == 33);
            we3 = (i % 3 == 0); a3 = 5'(i % 4);       wd3 = 32'h1000 + 32'(i);
            we4 = (i % 5 == 1); a4 = 5'((i + 1) % 4); wd4 = 32'h2000 + 32'(i);
            rsv = (i % 2 == 0); ra = 5'((i / 2) % 4);
            a1  = 5'(i % 4);    a2 = 5'((i + 2) % 4);
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
